// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO master.
// Clause 45 frames are accepted only when MDIO_CL45_EN is defined.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
    } state_t;

    localparam logic [1:0] ST_C22  = 2'b01;
    localparam logic [1:0] ST_C45  = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_PRIA = 2'b10;
    localparam logic [1:0] OP_RD45 = 2'b11;

    localparam int ST_MSB    = 31;
    localparam int OP_MSB    = 29;
    localparam int PHYAD_MSB = 27;
    localparam int REGAD_MSB = 22;
    localparam int TA_MSB    = 17;
    localparam int DATA_MSB  = 15;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    function automatic logic frame_legal(input logic [31:0] f);
        logic [1:0] st;
        logic [1:0] op;
        st = f[ST_MSB -: 2];
        op = f[OP_MSB -: 2];
`ifdef MDIO_CL45_EN
        return ((st == ST_C22) && ((op == OP_WR) || (op == OP_RD))) || (st == ST_C45);
`else
        return (st == ST_C22) && ((op == OP_WR) || (op == OP_RD));
`endif
    endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high while run is set.
// Strobes mark the clk edge at which mdc is about to rise or fall.
module mdio_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          wrap;

    always_comb begin
        wrap  = run && (cnt_q == LAST);
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!run) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc      = mdc_q;
    assign mdc_rise = wrap && !mdc_q;
    assign mdc_fall = wrap && mdc_q;

endmodule

// File: rtl/mdio_master.sv
// MDIO management master: serialises one 32-bit frame word behind a preamble.
// Build option MDIO_CL45_EN additionally accepts Clause 45 (ST=00) frames.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [15:0] rd_data,
    output logic        data_rdy,
    output logic        busy,
    output logic        err
);

    localparam int NBITS = PREAMBLE_LEN + 32;
    localparam int BW    = $clog2(NBITS);
    localparam logic [BW-1:0] PRE_W    = BW'(PREAMBLE_LEN);
    localparam logic [BW-1:0] LAST_PRE = BW'(PREAMBLE_LEN - 1);
    localparam logic [BW-1:0] HDR_END  = BW'(PREAMBLE_LEN + HDR_BITS - 1);
    localparam logic [BW-1:0] TA_END   = BW'(PREAMBLE_LEN + HDR_BITS + TA_BITS - 1);
    localparam logic [BW-1:0] DATA_END = BW'(NBITS - 1);

    state_t        state_q, state_d, nxt_st;
    logic [BW-1:0] bit_q, bit_d, nxt, rel;
    logic [31:0]   frame_q, frame_d;
    logic [15:0]   shadow_q, shadow_d, rd_data_q, rd_data_d;
    logic          mdio_out_q, mdio_out_d, mdio_oe_q, mdio_oe_d;
    logic          data_rdy_q, data_rdy_d, busy_q, busy_d, err_q, err_d;
    logic [4:0]    fidx;
    logic          run, mdc_rise, mdc_fall, rd;

    mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        shadow_d   = shadow_q;
        rd_data_d  = rd_data_q;
        mdio_out_d = mdio_out_q;
        mdio_oe_d  = mdio_oe_q;
        busy_d     = busy_q;
        data_rdy_d = 1'b0;
        err_d      = 1'b0;
        rd   = frame_q[OP_MSB];
        run  = state_q inside {S_PRE, S_HDR, S_TA, S_DATA};
        nxt  = bit_q + BW'(1);
        rel  = nxt - PRE_W;
        fidx = rel[4:0];

        // Phase boundaries are fixed positions in the bit stream.
        nxt_st = state_q;
        if (bit_q == DATA_END)                           nxt_st = S_DONE;
        else if (bit_q == TA_END)                        nxt_st = S_DATA;
        else if (bit_q == HDR_END)                       nxt_st = S_TA;
        else if (PREAMBLE_LEN != 0 && bit_q == LAST_PRE) nxt_st = S_HDR;

        case (state_q)
            S_IDLE: begin
                if (mdio_start) begin
                    frame_d = t_data;
                    state_d = S_CHECK;
                    // busy doubles as the legality flag seen by CHECK
                    if (frame_legal(t_data)) busy_d = 1'b1;
                    else                     err_d  = 1'b1;
                end
            end
            S_CHECK: begin
                if (!busy_q) begin
                    state_d = S_IDLE;
                end else begin
                    bit_d     = '0;
                    mdio_oe_d = 1'b1;
                    if (PREAMBLE_LEN == 0) begin
                        state_d    = S_HDR;
                        mdio_out_d = frame_q[31];
                    end else begin
                        state_d    = S_PRE;
                        mdio_out_d = 1'b1;
                    end
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (mdc_rise && state_q == S_DATA) shadow_d = {shadow_q[14:0], mdio_in};
                if (mdc_fall) begin
                    state_d = nxt_st;
                    bit_d   = nxt;
                    case (nxt_st)
                        S_PRE: begin
                            mdio_out_d = 1'b1;
                            mdio_oe_d  = 1'b1;
                        end
                        S_HDR: begin
                            mdio_out_d = frame_q[5'd31 - fidx];
                            mdio_oe_d  = 1'b1;
                        end
                        S_TA, S_DATA: begin
                            mdio_out_d = rd ? 1'b0 : frame_q[5'd31 - fidx];
                            mdio_oe_d  = !rd;
                        end
                        default: begin
                            mdio_out_d = 1'b0;
                            mdio_oe_d  = 1'b0;
                            bit_d      = '0;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (rd) begin
                    rd_data_d  = shadow_q;
                    data_rdy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_q      <= '0;
            frame_q    <= '0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
            mdio_out_q <= 1'b0;
            mdio_oe_q  <= 1'b0;
            data_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            mdio_out_q <= mdio_out_d;
            mdio_oe_q  <= mdio_oe_d;
            data_rdy_q <= data_rdy_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign mdio_out = mdio_out_q;
    assign mdio_oe  = mdio_oe_q;
    assign rd_data  = rd_data_q;
    assign data_rdy = data_rdy_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: default-parameter instance plus a CLK_DIV=1/no-preamble instance,
// a per-bit bus monitor with a PHY responder, and a frame-level expected-bit model.
module tb_mdio_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic [31:0] t_data;
    logic        mdio_in;
    logic        mdc1, mdio_out1, mdio_oe1, data_rdy1, busy1, err1;
    logic        mdc2, mdio_out2, mdio_oe2, data_rdy2, busy2, err2;
    logic [15:0] rd_data1, rd_data2;

    always #5 clk = ~clk;

    mdio_master dut (
        .clk(clk), .reset(reset), .mdio_start(start1), .t_data(t_data), .mdio_in(mdio_in),
        .mdc(mdc1), .mdio_out(mdio_out1), .mdio_oe(mdio_oe1), .rd_data(rd_data1),
        .data_rdy(data_rdy1), .busy(busy1), .err(err1)
    );

    mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut2 (
        .clk(clk), .reset(reset), .mdio_start(start2), .t_data(t_data), .mdio_in(mdio_in),
        .mdc(mdc2), .mdio_out(mdio_out2), .mdio_oe(mdio_oe2), .rd_data(rd_data2),
        .data_rdy(data_rdy2), .busy(busy2), .err(err2)
    );

    bit          sel;
    logic        m_mdc, m_out, m_oe, m_rdy, m_busy, m_err;
    logic [15:0] m_rd;
    assign m_mdc  = sel ? mdc2      : mdc1;
    assign m_out  = sel ? mdio_out2 : mdio_out1;
    assign m_oe   = sel ? mdio_oe2  : mdio_oe1;
    assign m_rdy  = sel ? data_rdy2 : data_rdy1;
    assign m_busy = sel ? busy2     : busy1;
    assign m_err  = sel ? err2      : err1;
    assign m_rd   = sel ? rd_data2  : rd_data1;

    int total = 0;
    int bad   = 0;

    // monitor state
    bit          mon_clr = 1'b0;
    int          mon_busy, mon_rdy, mon_err, mon_high, mon_unstable, mon_rises, mon_txn, mon_gap;
    logic [15:0] mon_rdval;
    bit          cap_out[$];
    bit          cap_oe[$];
    int          phy_pre = 32;
    logic [15:0] phy_val = 16'h0;

    bit          exp_out[$];
    bit          exp_oe[$];

    initial begin
        logic p_mdc, p_out, p_oe, p_busy;
        int   lowrun, nxt, k;
        mdio_in = 1'b0;
        p_mdc = 1'b0; p_out = 1'b0; p_oe = 1'b0; p_busy = 1'b0; lowrun = 0;
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                mon_busy = 0; mon_rdy = 0; mon_err = 0; mon_high = 0; mon_unstable = 0;
                mon_rises = 0; mon_txn = 0; mon_gap = -1; mon_rdval = 16'h0; lowrun = 0;
                cap_out.delete(); cap_oe.delete();
            end else begin
                if (m_busy) mon_busy++;
                if (m_busy && !p_busy) begin
                    if (mon_txn > 0) mon_gap = lowrun;
                    mon_txn++;
                end
                if (m_busy) lowrun = 0; else lowrun++;
                if (m_rdy) begin mon_rdy++; mon_rdval = m_rd; end
                if (m_err) mon_err++;
                if (m_mdc) mon_high++;
                if (m_mdc && ({m_out, m_oe} != {p_out, p_oe})) mon_unstable++;
                if (m_mdc && !p_mdc) begin
                    cap_out.push_back(m_out);
                    cap_oe.push_back(m_oe);
                    mon_rises++;
                end
                // PHY: after each falling MDC, present the bit for the next rising edge
                if (!m_mdc && p_mdc) begin
                    nxt = mon_rises + 1;
                    k   = nxt - phy_pre - 16;
                    if (k >= 1 && k <= 16) mdio_in = phy_val[16-k];
                    else                   mdio_in = ($urandom & 1) != 0;
                end
            end
            p_mdc = m_mdc; p_out = m_out; p_oe = m_oe; p_busy = m_busy;
        end
    end

    // Expected pins at every MDC rise, from the frame format alone.
    function automatic void build_exp(input logic [31:0] f, input int pre);
        bit rdf;
        rdf = f[29];
        exp_out.delete();
        exp_oe.delete();
        for (int i = 0; i < pre; i++) begin exp_out.push_back(1'b1); exp_oe.push_back(1'b1); end
        for (int j = 0; j < 32; j++) begin
            if (j < 14 || !rdf) begin exp_out.push_back(f[31-j]); exp_oe.push_back(1'b1); end
            else                begin exp_out.push_back(1'b0);    exp_oe.push_back(1'b0); end
        end
    endfunction

    function automatic int bit_errs();
        int n;
        if (cap_oe.size() != exp_oe.size()) return 1000 + cap_oe.size();
        n = 0;
        for (int i = 0; i < exp_oe.size(); i++)
            if (cap_oe[i] != exp_oe[i] || (exp_oe[i] && cap_out[i] != exp_out[i])) n++;
        return n;
    endfunction

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic send(input bit s2, input logic [31:0] f);
        @(negedge clk);
        t_data = f;
        if (s2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        bit seen;
        seen = m_busy;
        to   = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_busy) seen = 1'b1;
            else if (seen) begin to = 1'b0; break; end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start1 = 1'b0; start2 = 1'b0; t_data = 32'h0; sel = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mdc1, mdio_out1, mdio_oe1, data_rdy1, busy1, err1} !== 6'b0) begin
            bad++; $display("FAIL reset_pins1: got %b want 000000", {mdc1, mdio_out1, mdio_oe1, data_rdy1, busy1, err1});
        end
        total++;
        if (rd_data1 !== 16'h0) begin bad++; $display("FAIL reset_rd1: got %h want 0000", rd_data1); end
        total++;
        if ({mdc2, mdio_out2, mdio_oe2, data_rdy2, busy2, err2, rd_data2} !== 22'b0) begin
            bad++; $display("FAIL reset_dut2: got %h want 0", {mdc2, mdio_out2, mdio_oe2, data_rdy2, busy2, err2, rd_data2});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_fixed();
        logic [31:0] f;
        bit to;
        int e;
        sel = 1'b0; phy_pre = 32;
        f = {2'b01, 2'b01, 5'd5, 5'd3, 2'b10, 16'hBEEF};
        build_exp(f, 32);
        clr_mon();
        send(1'b0, f);
        total++;
        if (busy1 !== 1'b1 || err1 !== 1'b0) begin bad++; $display("FAIL wr_busy_t1: got busy=%b err=%b want 1 0", busy1, err1); end
        @(negedge clk);
        total++;
        if ({mdio_oe1, mdc1, mdio_out1} !== 3'b101) begin bad++; $display("FAIL wr_first_bit: got %b want 101", {mdio_oe1, mdc1, mdio_out1}); end
        wait_done(600, to);
        total++;
        if (to) begin bad++; $display("FAIL wr_timeout: got busy stuck want done"); end
        e = bit_errs();
        total++;
        if (e != 0) begin bad++; $display("FAIL wr_bits: got %0d bad bits want 0", e); end
        total++;
        if (mon_busy != 258) begin bad++; $display("FAIL wr_busy_len: got %0d want 258", mon_busy); end
        total++;
        if (mon_rdy != 0 || mon_err != 0) begin bad++; $display("FAIL wr_pulses: got rdy=%0d err=%0d want 0 0", mon_rdy, mon_err); end
        total++;
        if (mon_high != 128) begin bad++; $display("FAIL wr_mdc_high: got %0d want 128", mon_high); end
        total++;
        if (mon_unstable != 0) begin bad++; $display("FAIL wr_stable: got %0d changes while mdc high want 0", mon_unstable); end
        total++;
        if (mdc1 !== 1'b0 || mdio_oe1 !== 1'b0) begin bad++; $display("FAIL wr_idle_pins: got mdc=%b oe=%b want 0 0", mdc1, mdio_oe1); end
    endtask

    task automatic test_read_fixed();
        logic [31:0] f;
        bit to;
        int e;
        sel = 1'b0; phy_pre = 32; phy_val = 16'h1234;
        f = {2'b01, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000};
        build_exp(f, 32);
        clr_mon();
        send(1'b0, f);
        wait_done(600, to);
        total++;
        if (to) begin bad++; $display("FAIL rd_timeout: got busy stuck want done"); end
        e = bit_errs();
        total++;
        if (e != 0) begin bad++; $display("FAIL rd_bits: got %0d bad bits want 0", e); end
        total++;
        if (mon_busy != 258) begin bad++; $display("FAIL rd_busy_len: got %0d want 258", mon_busy); end
        total++;
        if (mon_rdy != 1) begin bad++; $display("FAIL rd_rdy_count: got %0d want 1", mon_rdy); end
        total++;
        if (mon_rdval !== 16'h1234) begin bad++; $display("FAIL rd_value: got %h want 1234", mon_rdval); end
        repeat (5) @(negedge clk);
        total++;
        if (rd_data1 !== 16'h1234) begin bad++; $display("FAIL rd_hold: got %h want 1234", rd_data1); end
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [15:0] last_rd;
        logic [1:0]  ta;
        bit rd, to;
        int e;
        sel = 1'b0; phy_pre = 32;
        last_rd = 16'h1234;
        for (int it = 0; it < 8; it++) begin
            rd = ($urandom & 1) != 0;
            ta = rd ? 2'b00 : 2'($urandom);
            f  = {2'b01, rd ? 2'b10 : 2'b01, 5'($urandom), 5'($urandom), ta, 16'($urandom)};
            phy_val = 16'($urandom);
            build_exp(f, 32);
            clr_mon();
            send(1'b0, f);
            wait_done(600, to);
            e = bit_errs();
            total++;
            if (to || e != 0 || mon_busy != 258) begin
                bad++; $display("FAIL rnd_frame%0d: got to=%0d badbits=%0d busy=%0d want 0 0 258", it, to, e, mon_busy);
            end
            if (rd) last_rd = phy_val;
            total++;
            if (mon_rdy != (rd ? 1 : 0)) begin bad++; $display("FAIL rnd_rdy%0d: got %0d want %0d", it, mon_rdy, rd ? 1 : 0); end
            total++;
            if (rd_data1 !== last_rd) begin bad++; $display("FAIL rnd_rd_data%0d: got %h want %h", it, rd_data1, last_rd); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_f[$];
        sel = 1'b0;
        bad_f.push_back({2'b11, 2'b01, 28'($urandom)});
        bad_f.push_back({2'b10, 2'b10, 28'($urandom)});
        bad_f.push_back({2'b01, 2'b00, 28'($urandom)});
        bad_f.push_back({2'b01, 2'b11, 28'($urandom)});
`ifndef MDIO_CL45_EN
        bad_f.push_back({2'b00, 2'b11, 28'($urandom)});
`endif
        foreach (bad_f[i]) begin
            clr_mon();
            send(1'b0, bad_f[i]);
            total++;
            if (err1 !== 1'b1 || busy1 !== 1'b0) begin
                bad++; $display("FAIL ill_err_t1_%0d: got err=%b busy=%b want 1 0", i, err1, busy1);
            end
            @(negedge clk);
            total++;
            if (err1 !== 1'b0) begin bad++; $display("FAIL ill_err_pulse_%0d: got %b want 0", i, err1); end
            repeat (20) @(negedge clk);
            total++;
            if (mon_rises != 0 || mon_busy != 0 || mon_err != 1) begin
                bad++; $display("FAIL ill_quiet_%0d: got rises=%0d busy=%0d err=%0d want 0 0 1", i, mon_rises, mon_busy, mon_err);
            end
        end
    endtask

`ifdef MDIO_CL45_EN
    task automatic test_cl45();
        logic [31:0] f;
        bit to;
        int e;
        sel = 1'b0; phy_pre = 32; phy_val = 16'($urandom);
        f = {2'b00, 2'b11, 5'($urandom), 5'($urandom), 2'b00, 16'h0};
        build_exp(f, 32);
        clr_mon();
        send(1'b0, f);
        wait_done(600, to);
        e = bit_errs();
        total++;
        if (to || e != 0 || mon_err != 0) begin bad++; $display("FAIL cl45_frame: got to=%0d badbits=%0d err=%0d want 0 0 0", to, e, mon_err); end
        total++;
        if (mon_rdy != 1 || mon_rdval !== phy_val) begin bad++; $display("FAIL cl45_rd: got rdy=%0d val=%h want 1 %h", mon_rdy, mon_rdval, phy_val); end
    endtask
`endif

    task automatic test_fast();
        logic [31:0] f;
        bit rd, to;
        int e;
        sel = 1'b1; phy_pre = 0;
        for (int it = 0; it < 3; it++) begin
            rd = (it != 2);
            f  = {2'b01, rd ? 2'b10 : 2'b01, 5'($urandom), 5'($urandom), 2'b10, 16'($urandom)};
            phy_val = 16'($urandom);
            build_exp(f, 0);
            clr_mon();
            send(1'b1, f);
            wait_done(200, to);
            e = bit_errs();
            total++;
            if (to || e != 0) begin bad++; $display("FAIL fast_bits%0d: got to=%0d badbits=%0d want 0 0", it, to, e); end
            total++;
            if (mon_busy != 66 || mon_high != 32 || mon_unstable != 0) begin
                bad++; $display("FAIL fast_timing%0d: got busy=%0d high=%0d unstable=%0d want 66 32 0", it, mon_busy, mon_high, mon_unstable);
            end
            if (rd) begin
                total++;
                if (mon_rdy != 1 || mon_rdval !== phy_val) begin
                    bad++; $display("FAIL fast_rd%0d: got rdy=%0d val=%h want 1 %h", it, mon_rdy, mon_rdval, phy_val);
                end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] f;
        bit to;
        int e;
        sel = 1'b0; phy_pre = 32; phy_val = 16'hA5C3;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        clr_mon();
        send(1'b0, {2'b01, 2'b10, 5'd7, 5'd9, 2'b00, 16'h0});
        to = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mon_rises >= 20) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL rst_reach_bit20: got %0d rises want 20", mon_rises); end
        reset = 1'b0;
        #1;
        total++;
        if ({mdio_oe1, mdc1, busy1} !== 3'b000) begin bad++; $display("FAIL rst_release: got oe,mdc,busy=%b want 000", {mdio_oe1, mdc1, busy1}); end
        total++;
        if (rd_data1 !== 16'h0) begin bad++; $display("FAIL rst_rd_data: got %h want 0000", rd_data1); end
        repeat (10) @(negedge clk);
        total++;
        if (mon_rdy != 0 || mon_err != 0) begin bad++; $display("FAIL rst_no_pulse: got rdy=%0d err=%0d want 0 0", mon_rdy, mon_err); end
        reset = 1'b1;
        @(negedge clk);
        f = {2'b01, 2'b01, 5'($urandom), 5'($urandom), 2'b10, 16'($urandom)};
        build_exp(f, 32);
        clr_mon();
        send(1'b0, f);
        wait_done(600, to);
        e = bit_errs();
        total++;
        if (to || e != 0 || mon_busy != 258) begin
            bad++; $display("FAIL rst_next_write: got to=%0d badbits=%0d busy=%0d want 0 0 258", to, e, mon_busy);
        end
        total++;
        if (rd_data1 !== 16'h0) begin bad++; $display("FAIL rst_rd_keep: got %h want 0000", rd_data1); end
    endtask

    task automatic test_hold_start();
        bit to;
        sel = 1'b0;
        clr_mon();
        @(negedge clk);
        t_data = {2'b01, 2'b01, 5'd2, 5'd4, 2'b10, 16'h55AA};
        start1 = 1'b1;
        repeat (300) @(negedge clk);
        start1 = 1'b0;
        wait_done(600, to);
        total++;
        if (to) begin bad++; $display("FAIL hold_timeout: got busy stuck want done"); end
        total++;
        if (mon_txn != 2) begin bad++; $display("FAIL hold_txn: got %0d want 2", mon_txn); end
        total++;
        if (mon_gap != 1 || mon_busy != 516) begin bad++; $display("FAIL hold_gap: got gap=%0d busy=%0d want 1 516", mon_gap, mon_busy); end
    endtask

    initial begin
        test_reset();
        test_write_fixed();
        test_read_fixed();
        test_random();
        test_illegal();
`ifdef MDIO_CL45_EN
        test_cl45();
`endif
        test_fast();
        test_reset_mid();
        test_hold_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
